// File: rtl/neo_frame_controller.sv
// neo_frame_controller
//
// Ping-pong frame scheduler for the NEO datapath. Incoming samples fill two
// M-deep banks alternately. Each full bank gets one calculator pass: the
// calculator's active-low reset is released for the pass, the calculator
// reads samples from the bank being processed, and its result writes are
// qualified into a validated result stream. The pass ends with either a
// frame_done pulse or, if the calculator never signals end-of-pass, an err
// pulse. In both cases the bank is dropped.
//
// State table
//   state | meaning
//   IDLE  | calculator held in reset, waiting for the next bank in fill order to be full
//   RUN   | calculator running; run_cnt follows the calculator's own cycle counter
//   DONE  | pass finished: frame_done pulse, bank released, frame_cnt incremented
//
// Ports
//   Clk, reset             clock (rising edge), asynchronous active-low reset
//   s_valid/s_data/s_ready sample input handshake
//   neo_rst_n              registered active-low reset to the calculator
//   neo_raddr/neo_rdata    calculator read port into the bank being processed
//   neo_waddr/neo_wdata    calculator result write port
//   neo_ready              calculator end-of-pass pulse
//   res_we/res_addr/res_data  qualified result stream
//   busy, frame_done, err  status; frame_done and err are one-cycle pulses
//   frame_cnt              completed-frame count, wraps at 256

module neo_frame_controller #(
    parameter int N = 16,
    parameter int M = 32
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   s_valid,
    input  logic signed [N-1:0]    s_data,
    output logic                   s_ready,
    output logic                   neo_rst_n,
    input  logic [$clog2(M)-1:0]   neo_raddr,
    output logic signed [N-1:0]    neo_rdata,
    input  logic [$clog2(M)-1:0]   neo_waddr,
    input  logic signed [N-1:0]    neo_wdata,
    input  logic                   neo_ready,
    output logic                   res_we,
    output logic [$clog2(M)-1:0]   res_addr,
    output logic signed [N-1:0]    res_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err,
    output logic [7:0]             frame_cnt
);

    localparam int AW = $clog2(M);
    localparam int CW = AW + 2;

    // run_cnt == M+3 is one cycle past the point where the calculator
    // should have raised neo_ready
    localparam logic [CW-1:0] CNT_TIMEOUT  = CW'(M + 3);
    // first and last run_cnt values carrying a valid interior result
    localparam logic [CW-1:0] CNT_WE_FIRST = CW'(2);
    localparam logic [CW-1:0] CNT_WE_LAST  = CW'(M - 1);
    localparam logic [AW-1:0] PTR_LAST     = AW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [N-1:0] bank [2][M];

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          fill_sel;
    logic          proc_sel;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] run_cnt;

    logic accept;
    logic fill_last;
    logic timeout;
    logic bank_free;

    // ------------------------------------------------------------------
    // Fill side
    // ------------------------------------------------------------------
    assign s_ready   = !full[fill_sel];
    assign accept    = s_valid && s_ready;
    assign fill_last = accept && (wr_ptr == PTR_LAST);

    // A bank is released either by a completed pass or by a timed-out one
    assign timeout   = (state == RUN) && !neo_ready && (run_cnt == CNT_TIMEOUT);
    assign bank_free = (state == DONE) || timeout;

    always_ff @(posedge Clk) begin
        if (accept) begin
            bank[fill_sel][wr_ptr] <= s_data;
        end
    end

    // Fill completion and release always target different banks (the
    // filling bank is not full, the processed one is), so both apply.
    always_comb begin
        full_nxt = full;
        if (bank_free) begin
            full_nxt[proc_sel] = 1'b0;
        end
        if (fill_last) begin
            full_nxt[fill_sel] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            full     <= '0;
            fill_sel <= 1'b0;
            wr_ptr   <= '0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wr_ptr <= fill_last ? '0 : wr_ptr + AW'(1);
                if (fill_last) begin
                    fill_sel <= !fill_sel;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Calculator side
    // ------------------------------------------------------------------
    assign neo_rdata = bank[proc_sel][neo_raddr];
    assign res_addr  = neo_waddr;
    assign res_data  = neo_wdata;

    // State register, with the pass bookkeeping that moves with it
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            run_cnt   <= '0;
            proc_sel  <= 1'b0;
            frame_cnt <= '0;
            neo_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            // registered so the calculator reset is glitch-free
            neo_rst_n <= (state_nxt == RUN);
            run_cnt   <= (state == RUN) ? run_cnt + CW'(1) : '0;
            if (bank_free) begin
                proc_sel <= !proc_sel;
            end
            if (state == DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (full[proc_sel]) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (neo_ready) begin
                    state_nxt = DONE;
                end else if (run_cnt == CNT_TIMEOUT) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        err        = timeout;
        // only interior results (addresses 1..M-2) are emitted
        res_we     = (state == RUN) && (run_cnt >= CNT_WE_FIRST) && (run_cnt <= CNT_WE_LAST);
    end

endmodule

// File: doc/neo_frame_controller.md
# neo_frame_controller

Ping-pong frame scheduler for the NEO datapath. It buffers an incoming sample stream into two M-deep banks. Each time a bank fills, it launches one NEO pass over that bank by pulsing the calculator's active-low reset. It serves the calculator's read port from the selected bank and qualifies the calculator's result writes into a validated result stream with per-frame completion and error signalling.

## Interface
Parameters:
- N, 16, sample/result width (signed)
- M, 32, samples per frame; power of two, ≥ 8

Ports:
- Clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_data  in  N  signed input sample
- s_ready  out  1  sample accepted when s_valid && s_ready
- neo_rst_n  out  1  registered active-low reset to calculator; low = calculator held idle
- neo_raddr  in  $clog2(M)  calculator read address
- neo_rdata  out  N  signed sample bank[proc_sel][neo_raddr], combinational read
- neo_waddr  in  $clog2(M)  calculator result address
- neo_wdata  in  N  signed calculator result
- neo_ready  in  1  calculator end-of-pass pulse
- res_we  out  1  result valid strobe
- res_addr  out  $clog2(M)  = neo_waddr
- res_data  out  N  = neo_wdata
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse, pass completed
- err  out  1  one-cycle pulse, pass timed out
- frame_cnt  out  8  completed-frame count, wraps 255→0

## Operation
- Storage: two banks of M×N; full[1:0], fill_sel, wr_ptr ($clog2(M) bits), proc_sel.
- Fill: s_ready = !full[fill_sel]. On accept, write bank[fill_sel][wr_ptr] and increment wr_ptr. When accepting at wr_ptr == M-1: set full[fill_sel], toggle fill_sel, wr_ptr → 0.
- Process order is strictly fill order: proc_sel selects the next bank to process.
- FSM IDLE / RUN / DONE:
  - IDLE: neo_rst_n = 0. If full[proc_sel], go to RUN; neo_rst_n ← 1 and run_cnt ← 0.
  - RUN: neo_rst_n = 1. run_cnt (width $clog2(M)+2) increments each cycle and tracks the calculator counter exactly.
    - If neo_ready = 1, go to DONE.
    - Else, if run_cnt == M+3, go to IDLE with err pulse; clear full[proc_sel] and toggle proc_sel (frame dropped).
  - DONE: neo_rst_n = 0, frame_done = 1, frame_cnt += 1, clear full[proc_sel], toggle proc_sel, go to IDLE.
- res_we = (state == RUN) && 2 ≤ run_cnt ≤ M-1. This yields M-2 writes with addresses 1..M-2. Edge results are not emitted.
- Result arithmetic is the calculator's; the controller passes data unmodified.
- A fill completion and a bank release in the same cycle are independent and both take effect. A bank released in DONE raises s_ready on the next cycle if fill_sel points at it.
- neo_ready asserted while in IDLE or DONE is ignored.

## Timing
- Reset (async, reset = 0) values:
  - state IDLE; full 00; fill_sel, proc_sel, wr_ptr = 0; frame_cnt 0
  - neo_rst_n 0; s_ready 1; res_we, busy, frame_done, err = 0
- Reset mid-RUN aborts the pass, discards both banks, and holds the calculator in reset.
- Relative to the edge E0 that accepts the last sample of a frame (controller idle):
  - E1: RUN entered, neo_rst_n rises.
  - res_we high in cycles after E3 … E(M).
  - neo_ready seen after E(M+3).
  - frame_done high for the single cycle after E(M+4).
- Back-to-back turnaround: DONE → IDLE → RUN costs 2 cycles between passes.
- Input stall: with both banks full, s_ready = 0 until the cycle after the first release.
- Timeout: err is high the cycle after edge E(M+4) when neo_ready never arrives.

## Test plan
- Reset: assert reset mid-stream → all outputs at reset values; s_ready = 1 immediately after release; frame_cnt = 0.
- Single frame, M = 32, samples x[i] = i → 30 res_we strobes, addr 1..30, every res_data = 1; frame_done one cycle after E36; frame_cnt = 1.
- Negative ramp x[i] = -3i → all 30 results = 9; signed handling confirmed.
- Continuous 96 samples with s_valid held high → s_ready drops after sample 64 and rises the cycle after the first frame_done. Three frame_done pulses in order, frame_cnt = 3, bank order preserved: frame 2 results derive from samples 32..63.
- Calculator model with neo_ready tied 0 → err pulse after E36, no frame_done, frame_cnt unchanged. The next frame processes the other bank normally.
- Reset asserted at run_cnt = 10 → res_we stops immediately, neo_rst_n = 0, no frame_done. A fresh 32-sample frame afterwards completes with frame_cnt = 1.
